// File: rtl/alu_cmd_queue.sv
// Command FIFO and issue stage for the combinational alu block.
// Queues (command, a, b), issues one op per EXEC cycle and holds the captured result for downstream.
module alu_cmd_queue #(
  parameter int unsigned SIZE  = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_command,
  input  logic [SIZE-1:0]              in_a,
  input  logic [SIZE-1:0]              in_b,
  output logic                         alu_enable,
  output logic [3:0]                   alu_command,
  output logic [SIZE-1:0]              alu_a,
  output logic [SIZE-1:0]              alu_b,
  input  logic                         alu_overflow,
  input  logic [2*SIZE-1:0]            alu_result,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_command,
  output logic [2*SIZE-1:0]            out_result,
  output logic                         out_overflow,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]      cmd;
    logic [SIZE-1:0] a;
    logic [SIZE-1:0] b;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [CW-1:0] count_nxt;
  entry_t        in_entry;
  entry_t        head;
  entry_t        issue;

  assign in_ready  = (count != CW'(DEPTH));
  assign push      = in_valid && in_ready;
  assign pop       = (state == EXEC);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign in_entry  = '{cmd: in_command, a: in_a, b: in_b};
  assign head      = mem[rd_ptr];
  // An op pushed into an empty queue in the same edge is issued directly from the inputs.
  assign issue     = (count == '0) ? in_entry : head;

  // Storage array; contents are qualified by count so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_entry;
    end
  end

  // Pointers, occupancy, issue FSM and registered ALU/output drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      alu_enable   <= 1'b0;
      alu_command  <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      out_valid    <= 1'b0;
      out_command  <= '0;
      out_result   <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count_nxt;

      case (state)
        IDLE: begin
          if (count != '0) begin
            state       <= EXEC;
            alu_enable  <= 1'b1;
            alu_command <= head.cmd;
            alu_a       <= head.a;
            alu_b       <= head.b;
          end
        end
        EXEC: begin
          state        <= DONE;
          alu_enable   <= 1'b0;
          alu_command  <= '0;
          alu_a        <= '0;
          alu_b        <= '0;
          out_valid    <= 1'b1;
          out_command  <= alu_command;
          out_result   <= alu_result;
          out_overflow <= alu_overflow;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (count_nxt != '0) begin
              state       <= EXEC;
              alu_enable  <= 1'b1;
              alu_command <= issue.cmd;
              alu_a       <= issue.a;
              alu_b       <= issue.b;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          alu_enable <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Directed bench for alu_cmd_queue with a small behavioural ALU attached.
module tb_alu_cmd_queue;
  localparam int unsigned SIZE  = 4;
  localparam int unsigned DEPTH = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_command;
  logic [SIZE-1:0]  in_a;
  logic [SIZE-1:0]  in_b;
  logic             alu_enable;
  logic [3:0]       alu_command;
  logic [SIZE-1:0]  alu_a;
  logic [SIZE-1:0]  alu_b;
  logic             alu_overflow;
  logic [2*SIZE-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_command;
  logic [2*SIZE-1:0] out_result;
  logic             out_overflow;
  logic [2:0]       count;

  int checks;
  int failures;
  int cyc;
  bit mon_on;
  logic [12:0] got_q[$];
  int          got_t[$];

  alu_cmd_queue #(.SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_command(in_command),
    .in_a(in_a), .in_b(in_b),
    .alu_enable(alu_enable), .alu_command(alu_command), .alu_a(alu_a), .alu_b(alu_b),
    .alu_overflow(alu_overflow), .alu_result(alu_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_command(out_command),
    .out_result(out_result), .out_overflow(out_overflow), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in ALU: 0=AND 1=OR 4=ADD 8=MUL, anything else returns {a,b} with ov=a[3].
  always_comb begin
    logic [7:0] wa;
    logic [7:0] wb;
    wa = 8'(alu_a);
    wb = 8'(alu_b);
    alu_result   = {alu_a, alu_b};
    alu_overflow = alu_a[3];
    case (alu_command)
      4'h0: begin alu_result = wa & wb; alu_overflow = 1'b0; end
      4'h1: begin alu_result = wa | wb; alu_overflow = 1'b0; end
      4'h4: begin alu_result = wa + wb; alu_overflow = ((wa + wb) > 8'd15); end
      4'h8: begin alu_result = wa * wb; alu_overflow = ((wa * wb) > 8'd15); end
      default: ;
    endcase
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_on && out_valid && out_ready) begin
      got_q.push_back({out_command, out_overflow, out_result});
      got_t.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b);
    in_valid   = 1'b1;
    in_command = c;
    in_a       = a;
    in_b       = b;
  endtask

  task automatic push_one(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b);
    drive(c, a, b);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    mon_on    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    got_q.delete();
    got_t.delete();
  endtask

  task automatic wait_valid(input string tag, input int max);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    checks = 0; failures = 0;
    in_valid = 0; in_command = 0; in_a = 0; in_b = 0; out_ready = 0; mon_on = 0;
    rst_n = 0;
    #2;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_alu_enable", 32'(alu_enable), 0);
    check("rst_count", 32'(count), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_result", 32'(out_result), 0);
    check("rst_out_cmd_ov", 32'({out_command, out_overflow}), 0);
    check("rst_alu_ops", 32'({alu_command, alu_a, alu_b}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // single op latency
    push_one(4'h0, 4'h7, 4'h3);
    check("single_t0_en", 32'(alu_enable), 0);
    check("single_t0_count", 32'(count), 1);
    tick();
    check("single_t1_en", 32'(alu_enable), 1);
    check("single_t1_ops", 32'({alu_command, alu_a, alu_b}), 32'h073);
    check("single_t1_valid", 32'(out_valid), 0);
    tick();
    check("single_t2_en", 32'(alu_enable), 0);
    check("single_t2_valid", 32'(out_valid), 1);
    check("single_t2_res", 32'({out_command, out_overflow, out_result}), 32'h003);
    check("single_t2_count", 32'(count), 0);
    out_ready = 1'b1;
    tick();
    check("single_done_valid", 32'(out_valid), 0);
    tick();
    check("single_idle_en", 32'(alu_enable), 0);

    // burst fill with backpressure
    do_reset();
    drive(4'h1, 4'h3, 4'hC); tick();
    for (int i = 1; i <= 4; i++) begin
      drive(4'hF, 4'(i), 4'(i + 8)); tick();
    end
    in_valid = 1'b0;
    check("burst_count", 32'(count), 4);
    check("burst_in_ready", 32'(in_ready), 0);
    check("burst_valid", 32'(out_valid), 1);
    check("burst_res", 32'(out_result), 32'h0F);
    push_one(4'hF, 4'h9, 4'h9);
    check("burst_6th_count", 32'(count), 4);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("burst_hold", 32'({out_valid, out_command, out_overflow, out_result, alu_enable}),
            32'({1'b1, 4'h1, 1'b0, 8'h0F, 1'b0}));
    end
    mon_on = 1'b1;
    out_ready = 1'b1;
    repeat (16) tick();
    check("burst_drain_n", 32'(got_q.size()), 5);
    if (got_q.size() == 5) begin
      check("burst_drain_0", 32'(got_q[0]), 32'({4'h1, 1'b0, 8'h0F}));
      for (int i = 1; i <= 4; i++)
        check("burst_drain_i", 32'(got_q[i]), 32'({4'hF, 1'b0, 4'(i), 4'(i + 8)}));
    end

    // drain order and spacing
    do_reset();
    out_ready = 1'b1;
    mon_on = 1'b1;
    drive(4'h1, 4'hA, 4'h5); tick();
    drive(4'h4, 4'h7, 4'h1); tick();
    drive(4'h8, 4'h7, 4'h8); tick();
    in_valid = 1'b0;
    repeat (12) tick();
    check("drain_n", 32'(got_q.size()), 3);
    if (got_q.size() == 3) begin
      check("drain_0", 32'(got_q[0]), 32'({4'h1, 1'b0, 8'h0F}));
      check("drain_1", 32'(got_q[1]), 32'({4'h4, 1'b0, 8'h08}));
      check("drain_2", 32'(got_q[2]), 32'({4'h8, 1'b1, 8'h38}));
      check("drain_gap_1", 32'(got_t[1] - got_t[0]), 2);
      check("drain_gap_2", 32'(got_t[2] - got_t[1]), 2);
    end

    // simultaneous push/pop with pointer wrap
    do_reset();
    out_ready = 1'b1;
    mon_on = 1'b1;
    drive(4'hF, 4'd0, 4'd15); tick();
    drive(4'hF, 4'd1, 4'd14); tick();
    in_valid = 1'b0;
    begin
      int pushed;
      int guard;
      pushed = 2;
      guard = 0;
      while (pushed < 10 && guard < 60) begin
        if (alu_enable) begin
          check("pp_pre_count", 32'(count), 2);
          push_one(4'hF, 4'(pushed), 4'(15 - pushed));
          check("pp_post_count", 32'(count), 2);
          pushed++;
        end else begin
          tick();
        end
        guard++;
      end
      check("pp_pushed", 32'(pushed), 10);
    end
    repeat (16) tick();
    check("pp_n", 32'(got_q.size()), 10);
    if (got_q.size() == 10) begin
      for (int i = 0; i < 10; i++) begin
        logic [3:0] ea;
        ea = 4'(i);
        check("pp_item", 32'(got_q[i]), 32'({4'hF, ea[3], ea, 4'(15 - i)}));
      end
    end

    // empty-queue fast path from DONE
    do_reset();
    push_one(4'h0, 4'hF, 4'h6);
    wait_valid("fast_first_valid", 10);
    check("fast_first_res", 32'(out_result), 32'h06);
    check("fast_first_count", 32'(count), 0);
    out_ready = 1'b1;
    push_one(4'h4, 4'h9, 4'h9);
    check("fast_exec_en", 32'(alu_enable), 1);
    check("fast_exec_ops", 32'({alu_command, alu_a, alu_b}), 32'h499);
    check("fast_exec_valid", 32'(out_valid), 0);
    check("fast_exec_count", 32'(count), 1);
    tick();
    check("fast_res", 32'({out_valid, out_command, out_overflow, out_result}),
          32'({1'b1, 4'h4, 1'b1, 8'h12}));
    check("fast_count", 32'(count), 0);

    // reset during EXEC with entries queued
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(4'hF, 4'(i + 5), 4'h1); tick();
    end
    in_valid = 1'b0;
    check("mid_pre_en", 32'(alu_enable), 1);
    check("mid_pre_count", 32'(count), 3);
    check("mid_pre_res", 32'(out_result), 32'h51);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 0);
    check("mid_rst_en", 32'(alu_enable), 0);
    check("mid_rst_count", 32'(count), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    check("mid_rst_res", 32'(out_result), 0);
    check("mid_rst_ops", 32'({alu_command, alu_a, alu_b}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_on = 1'b1;
    push_one(4'h0, 4'hC, 4'hA);
    check("mid_t0_en", 32'(alu_enable), 0);
    tick();
    check("mid_t1_en", 32'(alu_enable), 1);
    check("mid_t1_a", 32'(alu_a), 32'hC);
    tick();
    check("mid_t2_res", 32'({out_valid, out_command, out_overflow, out_result}),
          32'({1'b1, 4'h0, 1'b0, 8'h08}));
    repeat (10) tick();
    check("mid_no_stale", 32'(got_q.size()), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
